// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO sweep sequencer.
package nco_pkg;

    localparam int unsigned FW_W_DEF = 20;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam logic MODE_SAW = 1'b0;
    localparam logic MODE_TRI = 1'b1;

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Host/NCO-side signal bundle of the sweep sequencer.
interface nco_sweep_ctrl_if
    import nco_pkg::*;
#(
    parameter int unsigned FW_W     = FW_W_DEF,
    parameter int unsigned DWELL_W  = 16,
    parameter int unsigned SWEEPS_W = 8
);
    logic                start;
    logic                abort;
    logic [FW_W-1:0]     cfg_start_word;
    logic [FW_W-1:0]     cfg_stop_word;
    logic [FW_W-1:0]     cfg_step_word;
    logic [DWELL_W-1:0]  cfg_dwell;
    logic                cfg_mode;
    logic [SWEEPS_W-1:0] cfg_num_sweeps;
    logic                cfg_iq_sel;
    logic [FW_W-1:0]     freq_word;
    logic                nco_enable;
    logic                sin_cos_sel;
    logic                busy;
    logic                cfg_err;
    logic                sweep_done;
    logic                all_done;
    logic [SWEEPS_W-1:0] sweep_cnt;

    modport slave (
        input  start, abort, cfg_start_word, cfg_stop_word, cfg_step_word, cfg_dwell,
               cfg_mode, cfg_num_sweeps, cfg_iq_sel,
        output freq_word, nco_enable, sin_cos_sel, busy, cfg_err, sweep_done, all_done,
               sweep_cnt
    );

    modport master (
        output start, abort, cfg_start_word, cfg_stop_word, cfg_step_word, cfg_dwell,
               cfg_mode, cfg_num_sweeps, cfg_iq_sel,
        input  freq_word, nco_enable, sin_cos_sel, busy, cfg_err, sweep_done, all_done,
               sweep_cnt
    );

endinterface

// File: rtl/nco_step_unit.sv
// Saturating frequency step: up clamps to i_hi, down clamps to i_lo; never wraps.
module nco_step_unit
    import nco_pkg::*;
#(
    parameter int unsigned FW_W = FW_W_DEF
) (
    input  logic [FW_W-1:0] i_cur,
    input  logic [FW_W-1:0] i_step,
    input  logic [FW_W-1:0] i_lo,
    input  logic [FW_W-1:0] i_hi,
    input  logic            i_down,
    output logic [FW_W-1:0] o_next
);

    logic [FW_W:0] w_sum;
    logic [FW_W:0] w_diff;

    always_comb begin
        w_sum  = {1'b0, i_cur} + {1'b0, i_step};
        w_diff = {1'b0, i_cur} - {1'b0, i_step};
        o_next = '0;
        if (i_down) begin
            // Top bit of the difference is the borrow.
            if (w_diff[FW_W] || (w_diff[FW_W-1:0] <= i_lo)) o_next = i_lo;
            else                                            o_next = w_diff[FW_W-1:0];
        end else begin
            if (w_sum >= {1'b0, i_hi}) o_next = i_hi;
            else                       o_next = w_sum[FW_W-1:0];
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer driving the NCO tuning inputs.
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int unsigned FW_W     = FW_W_DEF,
    parameter int unsigned DWELL_W  = 16,
    parameter int unsigned SWEEPS_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    nco_sweep_ctrl_if.slave io_sweep
);

    state_e              r_state;
    logic [FW_W-1:0]     r_start, r_stop, r_step, r_cur;
    logic [DWELL_W-1:0]  r_dwell, r_dwell_cnt;
    logic [SWEEPS_W-1:0] r_num, r_sweep_cnt;
    logic                r_mode, r_iq, r_down;
    logic                r_busy, r_nco_en, r_cfg_err, r_sweep_done, r_all_done;

    logic                w_cfg_bad, w_at_stop, w_at_end, w_step_down, w_last;
    logic                w_down_n, w_end_n, w_done_n;
    logic [FW_W-1:0]     w_step_next, w_adv_pt, w_pt_n;
    logic [DWELL_W-1:0]  w_dwell_n;
    logic [SWEEPS_W-1:0] w_cnt_inc;

    nco_step_unit #(
        .FW_W (FW_W)
    ) u_step (
        .i_cur  (r_cur),
        .i_step (r_step),
        .i_lo   (r_start),
        .i_hi   (r_stop),
        .i_down (w_step_down),
        .o_next (w_step_next)
    );

    assign w_cnt_inc = r_sweep_cnt + 1'b1;

    always_comb begin
        w_cfg_bad   = (io_sweep.cfg_step_word == '0) ||
                      (io_sweep.cfg_start_word >= io_sweep.cfg_stop_word);
        w_at_stop   = (r_cur == r_stop);
        w_at_end    = (r_mode == MODE_TRI) ? (r_down && (r_cur == r_start)) : w_at_stop;
        // Triangle turns down at stop and back up after the start point, without repeats.
        w_step_down = (r_mode == MODE_TRI) && (r_down ? !w_at_end : w_at_stop);
        w_adv_pt    = ((r_mode == MODE_SAW) && w_at_end) ? r_start : w_step_next;
        w_last      = (r_dwell_cnt == '0);
        w_pt_n      = w_last ? w_adv_pt : r_cur;
        w_down_n    = w_last ? w_step_down : r_down;
        w_dwell_n   = w_last ? r_dwell : (r_dwell_cnt - 1'b1);
        w_end_n     = (r_mode == MODE_TRI) ? (w_down_n && (w_pt_n == r_start))
                                           : (w_pt_n == r_stop);
        // Completion flags are looked ahead one cycle so they stay registered.
        w_done_n    = (w_dwell_n == '0) && w_end_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_start      <= '0;
            r_stop       <= '0;
            r_step       <= '0;
            r_cur        <= '0;
            r_dwell      <= '0;
            r_dwell_cnt  <= '0;
            r_num        <= '0;
            r_sweep_cnt  <= '0;
            r_mode       <= 1'b0;
            r_iq         <= 1'b0;
            r_down       <= 1'b0;
            r_busy       <= 1'b0;
            r_nco_en     <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_sweep_done <= 1'b0;
            r_all_done   <= 1'b0;
        end else begin
            r_cfg_err    <= 1'b0;
            r_sweep_done <= 1'b0;
            r_all_done   <= 1'b0;
            if (io_sweep.abort) begin
                r_state     <= StIdle;
                r_busy      <= 1'b0;
                r_nco_en    <= 1'b0;
                r_cur       <= '0;
                r_down      <= 1'b0;
                r_dwell_cnt <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (io_sweep.start) begin
                            if (w_cfg_bad) begin
                                r_cfg_err <= 1'b1;
                            end else begin
                                r_start     <= io_sweep.cfg_start_word;
                                r_stop      <= io_sweep.cfg_stop_word;
                                r_step      <= io_sweep.cfg_step_word;
                                r_dwell     <= io_sweep.cfg_dwell;
                                r_mode      <= io_sweep.cfg_mode;
                                r_num       <= io_sweep.cfg_num_sweeps;
                                r_iq        <= io_sweep.cfg_iq_sel;
                                r_sweep_cnt <= '0;
                                r_cur       <= io_sweep.cfg_start_word;
                                r_dwell_cnt <= io_sweep.cfg_dwell;
                                r_down      <= 1'b0;
                                r_busy      <= 1'b1;
                                r_nco_en    <= 1'b1;
                                r_state     <= StRun;
                            end
                        end
                    end
                    StRun: begin
                        if (r_sweep_done) r_sweep_cnt <= w_cnt_inc;
                        if (r_all_done) begin
                            r_state     <= StIdle;
                            r_busy      <= 1'b0;
                            r_nco_en    <= 1'b0;
                            r_cur       <= '0;
                            r_down      <= 1'b0;
                            r_dwell_cnt <= '0;
                        end else begin
                            r_cur        <= w_pt_n;
                            r_down       <= w_down_n;
                            r_dwell_cnt  <= w_dwell_n;
                            r_sweep_done <= w_done_n;
                            r_all_done   <= w_done_n && (r_num != '0) && (w_cnt_inc == r_num);
                        end
                    end
                endcase
            end
        end
    end

    assign io_sweep.freq_word   = r_cur;
    assign io_sweep.nco_enable  = r_nco_en;
    assign io_sweep.sin_cos_sel = r_iq;
    assign io_sweep.busy        = r_busy;
    assign io_sweep.cfg_err     = r_cfg_err;
    assign io_sweep.sweep_done  = r_sweep_done;
    assign io_sweep.all_done    = r_all_done;
    assign io_sweep.sweep_cnt   = r_sweep_cnt;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed and random sweeps against a point-list model.
module tb_nco_sweep_ctrl;
    import nco_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [19:0] exp_freq[$];
    bit          exp_sd[$];
    bit          exp_ad[$];

    always #5 clk = ~clk;

    nco_sweep_ctrl_if #(.FW_W(20), .DWELL_W(16), .SWEEPS_W(8)) sw_if ();

    nco_sweep_ctrl #(
        .FW_W     (20),
        .DWELL_W  (16),
        .SWEEPS_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_sweep (sw_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int s, input int e, input int st, input int dw,
                           input bit md, input int ns, input bit iq);
        sw_if.cfg_start_word = 20'(s);
        sw_if.cfg_stop_word  = 20'(e);
        sw_if.cfg_step_word  = 20'(st);
        sw_if.cfg_dwell      = 16'(dw);
        sw_if.cfg_mode       = md;
        sw_if.cfg_num_sweeps = 8'(ns);
        sw_if.cfg_iq_sel     = iq;
    endtask

    task automatic scramble_cfg();
        set_cfg(int'($urandom_range(0, 20'hFFFFF)), int'($urandom_range(0, 20'hFFFFF)),
                int'($urandom_range(0, 20'hFFFFF)), int'($urandom_range(0, 9)),
                1'($urandom), int'($urandom_range(0, 255)), 1'($urandom));
    endtask

    // Expected per-cycle freq word and pulses, from the list of sweep points.
    task automatic build_model(input longint s, input longint e, input longint st,
                               input int dw, input bit md, input int ns);
        longint pts[$];
        longint p;
        exp_freq.delete();
        exp_sd.delete();
        exp_ad.delete();
        p = s;
        pts.push_back(p);
        while (p != e) begin
            if (p + st >= e) p = e;
            else             p = p + st;
            pts.push_back(p);
        end
        if (md) begin
            while (p != s) begin
                if (p - st <= s) p = s;
                else             p = p - st;
                pts.push_back(p);
            end
        end
        for (int sw = 0; sw < ns; sw++) begin
            for (int k = ((md && sw > 0) ? 1 : 0); k < pts.size(); k++) begin
                for (int d = 0; d <= dw; d++) begin
                    exp_freq.push_back(20'(pts[k]));
                    exp_sd.push_back((k == pts.size() - 1) && (d == dw));
                    exp_ad.push_back((k == pts.size() - 1) && (d == dw) && (sw == ns - 1));
                end
            end
        end
    endtask

    task automatic test_reset();
        sw_if.start = 1'b0;
        sw_if.abort = 1'b0;
        set_cfg(0, 0, 0, 0, 1'b0, 0, 1'b0);
        rst = 1'b1;
        #3;
        checks++;
        if ({sw_if.freq_word, sw_if.nco_enable, sw_if.sin_cos_sel, sw_if.busy, sw_if.cfg_err,
             sw_if.sweep_done, sw_if.all_done, sw_if.sweep_cnt} !== 34'h0) begin
            errors++;
            $display("FAIL reset_outputs: freq=%h en=%b busy=%b cnt=%0d, required all zero",
                     sw_if.freq_word, sw_if.nco_enable, sw_if.busy, sw_if.sweep_cnt);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({sw_if.busy, sw_if.nco_enable, sw_if.freq_word} !== 22'h0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b en=%b freq=%h, required 0 0 00000",
                     sw_if.busy, sw_if.nco_enable, sw_if.freq_word);
        end
    endtask

    task automatic test_sweeps();
        for (int n = 0; n < 14; n++) begin
            int s, e, st, dw, ns, span;
            bit md, iq;
            case (n)
                0: begin s = 'h01000; e = 'h01400; st = 'h100;   dw = 3; md = 0; ns = 2; iq = 0; end
                1: begin s = 'h00000; e = 'h00250; st = 'h100;   dw = 0; md = 0; ns = 1; iq = 1; end
                2: begin s = 'h90000; e = 'hFFFFF; st = 'h80000; dw = 1; md = 0; ns = 1; iq = 0; end
                3: begin s = 'h00100; e = 'h00300; st = 'h100;   dw = 0; md = 1; ns = 1; iq = 1; end
                default: begin
                    s    = int'($urandom_range(0, 20'hFFFF0));
                    span = int'($urandom_range(1, 20'hFFFFF - s));
                    e    = s + span;
                    st   = span / int'($urandom_range(1, 10)) + int'($urandom_range(0, 3));
                    if (st == 0) st = 1;
                    dw   = int'($urandom_range(0, 3));
                    md   = 1'($urandom);
                    ns   = int'($urandom_range(1, 3));
                    iq   = 1'($urandom);
                end
            endcase
            build_model(longint'(s), longint'(e), longint'(st), dw, md, ns);
            set_cfg(s, e, st, dw, md, ns, iq);
            sw_if.start = 1'b1;
            tick();
            sw_if.start = 1'b0;
            scramble_cfg();
            for (int i = 0; i < exp_freq.size(); i++) begin
                checks++;
                if (sw_if.freq_word !== exp_freq[i]) begin
                    errors++;
                    $display("FAIL sweep%0d_freq cyc %0d: got %h, required %h",
                             n, i + 1, sw_if.freq_word, exp_freq[i]);
                end
                checks++;
                if ({sw_if.sweep_done, sw_if.all_done} !== {exp_sd[i], exp_ad[i]}) begin
                    errors++;
                    $display("FAIL sweep%0d_pulses cyc %0d: sd/ad got %b%b, required %b%b", n,
                             i + 1, sw_if.sweep_done, sw_if.all_done, exp_sd[i], exp_ad[i]);
                end
                checks++;
                if ({sw_if.nco_enable, sw_if.busy, sw_if.sin_cos_sel} !== {2'b11, iq}) begin
                    errors++;
                    $display("FAIL sweep%0d_status cyc %0d: en/busy/iq got %b%b%b, required 11%b",
                             n, i + 1, sw_if.nco_enable, sw_if.busy, sw_if.sin_cos_sel, iq);
                end
                tick();
            end
            checks++;
            if ({sw_if.busy, sw_if.nco_enable, sw_if.freq_word, sw_if.sweep_cnt,
                 sw_if.sin_cos_sel} !== {22'h0, 8'(ns), iq}) begin
                errors++;
                $display("FAIL sweep%0d_end: busy=%b en=%b freq=%h cnt=%0d iq=%b, required 0 0 0 %0d %b",
                         n, sw_if.busy, sw_if.nco_enable, sw_if.freq_word, sw_if.sweep_cnt,
                         sw_if.sin_cos_sel, ns, iq);
            end
        end
    endtask

    task automatic test_cfg_err();
        for (int n = 0; n < 3; n++) begin
            case (n)
                0:       set_cfg('h100, 'h400, 0,     2, 1'b0, 1, 1'b0);
                1:       set_cfg('h300, 'h300, 'h10, 2, 1'b0, 1, 1'b0);
                default: set_cfg('h500, 'h200, 'h10, 2, 1'b1, 1, 1'b0);
            endcase
            sw_if.start = 1'b1;
            tick();
            sw_if.start = 1'b0;
            checks++;
            if ({sw_if.cfg_err, sw_if.busy, sw_if.nco_enable} !== 3'b100) begin
                errors++;
                $display("FAIL cfg_err%0d_pulse: err/busy/en got %b%b%b, required 100",
                         n, sw_if.cfg_err, sw_if.busy, sw_if.nco_enable);
            end
            tick();
            checks++;
            if ({sw_if.cfg_err, sw_if.busy} !== 2'b00) begin
                errors++;
                $display("FAIL cfg_err%0d_one_cycle: err/busy got %b%b, required 00",
                         n, sw_if.cfg_err, sw_if.busy);
            end
        end
    endtask

    task automatic test_abort();
        // Continuous run, aborted in the middle of a dwell in the second sweep.
        build_model('h100, 'h400, 'h100, 5, 1'b0, 2);
        set_cfg('h100, 'h400, 'h100, 5, 1'b0, 0, 1'b1);
        sw_if.start = 1'b1;
        tick();
        sw_if.start = 1'b0;
        for (int i = 0; i < 28; i++) begin
            checks++;
            if ({sw_if.freq_word, sw_if.sweep_done, sw_if.all_done} !==
                {exp_freq[i], exp_sd[i], 1'b0}) begin
                errors++;
                $display("FAIL abort_run cyc %0d: freq=%h sd=%b ad=%b, required %h %b 0",
                         i + 1, sw_if.freq_word, sw_if.sweep_done, sw_if.all_done,
                         exp_freq[i], exp_sd[i]);
            end
            if (i < 27) tick();
        end
        checks++;
        if (sw_if.sweep_cnt !== 8'd1) begin
            errors++;
            $display("FAIL abort_cont_count: got %0d, required 1", sw_if.sweep_cnt);
        end
        sw_if.abort = 1'b1;
        tick();
        sw_if.abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({sw_if.busy, sw_if.nco_enable, sw_if.freq_word, sw_if.sweep_done,
                 sw_if.all_done} !== 24'h0) begin
                errors++;
                $display("FAIL abort_idle cyc %0d: busy=%b en=%b freq=%h sd=%b ad=%b, required 0",
                         i, sw_if.busy, sw_if.nco_enable, sw_if.freq_word, sw_if.sweep_done,
                         sw_if.all_done);
            end
            tick();
        end
        set_cfg('h100, 'h400, 'h100, 1, 1'b0, 1, 1'b0);
        sw_if.start = 1'b1;
        sw_if.abort = 1'b1;
        tick();
        sw_if.start = 1'b0;
        sw_if.abort = 1'b0;
        checks++;
        if ({sw_if.busy, sw_if.nco_enable, sw_if.cfg_err} !== 3'b000) begin
            errors++;
            $display("FAIL abort_beats_start: busy/en/err got %b%b%b, required 000",
                     sw_if.busy, sw_if.nco_enable, sw_if.cfg_err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            if (r == 0) begin
                build_model('h1000, 'h1400, 'h100, 3, 1'b0, 2);
                set_cfg('h1000, 'h1400, 'h100, 3, 1'b0, 2, 1'b0);
            end else begin
                build_model('h200, 'h500, 'hC0, 1, 1'b1, 2);
                set_cfg('h200, 'h500, 'hC0, 1, 1'b1, 2, 1'b1);
            end
            sw_if.start = 1'b1;
            tick();
            for (int i = 0; i < exp_freq.size(); i++) begin
                checks++;
                if ({sw_if.freq_word, sw_if.sweep_done, sw_if.all_done, sw_if.cfg_err} !==
                    {exp_freq[i], exp_sd[i], exp_ad[i], 1'b0}) begin
                    errors++;
                    $display("FAIL busy_start%0d cyc %0d: freq=%h sd=%b ad=%b err=%b, required %h %b %b 0",
                             r, i + 1, sw_if.freq_word, sw_if.sweep_done, sw_if.all_done,
                             sw_if.cfg_err, exp_freq[i], exp_sd[i], exp_ad[i]);
                end
                // Hammer start and cfg while busy; leave start low for the idle cycle.
                sw_if.start = (i == exp_freq.size() - 1) ? 1'b0 : 1'($urandom);
                scramble_cfg();
                tick();
            end
            checks++;
            if ({sw_if.busy, sw_if.sweep_cnt} !== {1'b0, 8'd2}) begin
                errors++;
                $display("FAIL busy_start%0d_end: busy=%b cnt=%0d, required 0 2",
                         r, sw_if.busy, sw_if.sweep_cnt);
            end
        end
    endtask

    task automatic test_reset_midrun();
        set_cfg('h1000, 'h1400, 'h100, 3, 1'b0, 2, 1'b1);
        sw_if.start = 1'b1;
        tick();
        sw_if.start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({sw_if.freq_word, sw_if.nco_enable, sw_if.sin_cos_sel, sw_if.busy, sw_if.cfg_err,
             sw_if.sweep_done, sw_if.all_done, sw_if.sweep_cnt} !== 34'h0) begin
            errors++;
            $display("FAIL reset_midrun: freq=%h en=%b iq=%b busy=%b, required all zero",
                     sw_if.freq_word, sw_if.nco_enable, sw_if.sin_cos_sel, sw_if.busy);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({sw_if.busy, sw_if.nco_enable, sw_if.sweep_done, sw_if.all_done} !== 4'h0) begin
            errors++;
            $display("FAIL reset_midrun_stays_idle: busy=%b en=%b sd=%b ad=%b, required 0",
                     sw_if.busy, sw_if.nco_enable, sw_if.sweep_done, sw_if.all_done);
        end
    endtask

    initial begin
        test_reset();
        test_sweeps();
        test_cfg_err();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
